// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int ZERO_IDX  = 0;

  // Index width for a register count; never narrower than one bit.
  function automatic int idx_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int DEF_AW = idx_width(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_idx_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_index,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_index,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_index,
  output logic [NRD-1:0]    busy,
  output logic              pend_any
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic             pend_any_q, pend_any_d;

  // Issue is applied after the clear so a new producer supersedes the old one.
  always_comb begin
    pend_d = pend_q;
    if (wr_en)
      pend_d[wr_index] = 1'b0;
    if (issue_en)
      pend_d[issue_index] = 1'b1;
    if (ZERO_REG != 0)
      pend_d[ZERO_IDX] = 1'b0;
    pend_any_d = |pend_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      pend_any_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_any_q <= pend_any_d;
    end
  end

  assign pend_any = pend_any_q;

  for (genvar p = 0; p < NRD; p++) begin : g_busy
    logic [AW-1:0] idx;
    logic          fwd;
    logic          reissue;
    logic          busy_c;

    assign idx = rd_index[p*AW +: AW];

    always_comb begin
      fwd     = (BYPASS != 0) && wr_en && (wr_index == idx)
                && !((ZERO_REG != 0) && (idx == AW'(ZERO_IDX)));
      reissue = issue_en && (issue_index == idx);
      busy_c  = rd_en[p] && pend_q[idx] && !(fwd && !reissue);
    end

    assign busy[p] = busy_c;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with bypass, zero register,
// optional registered read and a pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NRD       = 2,
  parameter int SYNC_READ = 0,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  localparam int AW       = idx_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_index,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_index,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_index,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_valid,
  output logic [NRD-1:0]      rd_busy,
  output logic                pend_any
);

  logic [XLEN-1:0]     mem_q [NREGS];
  logic [XLEN-1:0]     mem_d [NREGS];
  logic                wr_ok;
  logic [NRD*XLEN-1:0] rd_val_c;
  logic [NRD-1:0]      busy_c;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_index == AW'(ZERO_IDX)));

  always_comb begin
    mem_d = mem_q;
    if (wr_ok)
      mem_d[wr_index] = wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++)
        mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .AW       (AW),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .issue_en    (issue_en),
    .issue_index (issue_index),
    .rd_en       (rd_en),
    .rd_index    (rd_index),
    .busy        (busy_c),
    .pend_any    (pend_any)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   idx;
    logic            hit;
    logic [XLEN-1:0] val;

    assign idx = rd_index[p*AW +: AW];

    always_comb begin
      hit = (BYPASS != 0) && wr_en && (wr_index == idx)
            && !((ZERO_REG != 0) && (idx == AW'(ZERO_IDX)));
      val = '0;
      if (!rd_en[p])
        val = '0;
      else if ((ZERO_REG != 0) && (idx == AW'(ZERO_IDX)))
        val = '0;
      else if (hit)
        val = wr_data;
      else
        val = mem_q[idx];
    end

    assign rd_val_c[p*XLEN +: XLEN] = val;
  end

  if (SYNC_READ != 0) begin : g_sync
    logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NRD-1:0]      rd_valid_q, rd_valid_d;
    logic [NRD-1:0]      rd_busy_q, rd_busy_d;

    // Disabled ports already carry zero data and zero busy from the read stage.
    always_comb begin
      rd_data_d  = rd_val_c;
      rd_valid_d = rd_en;
      rd_busy_d  = busy_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= '0;
        rd_busy_q  <= '0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
        rd_busy_q  <= rd_busy_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_busy  = rd_busy_q;
  end else begin : g_comb
    assign rd_data  = rd_val_c;
    assign rd_valid = rd_en;
    assign rd_busy  = busy_c;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: a combinational/bypass/zero-reg instance and a
// registered/no-bypass/64-bit/4-port instance driven with the same stimulus.
module tb_regfile_mp;

  logic clk;
  logic reset_n;

  // Logical stimulus shared by both instances
  logic        s_wr_en;
  logic [4:0]  s_wr_idx;
  logic [31:0] s_wr_data;
  logic        s_iss_en;
  logic [4:0]  s_iss_idx;
  logic [3:0]  s_rd_en;
  logic [4:0]  s_rd_idx [4];

  // Instance A: XLEN 32, 32 regs, 2 ports, comb read, bypass, zero reg
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_valid, a_rd_busy;
  logic        a_pend_any;
  logic [9:0]  a_rd_index;

  // Instance B: XLEN 64, 16 regs, 4 ports, registered read, no bypass, no zero reg
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_valid, b_rd_busy;
  logic         b_pend_any;
  logic [15:0]  b_rd_index;
  logic [63:0]  b_wr_data;

  assign a_rd_index = {s_rd_idx[1], s_rd_idx[0]};
  assign b_rd_index = {s_rd_idx[3][3:0], s_rd_idx[2][3:0], s_rd_idx[1][3:0], s_rd_idx[0][3:0]};
  assign b_wr_data  = {s_wr_data ^ 32'h5A5A5A5A, s_wr_data};

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .SYNC_READ(0), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .wr_en(s_wr_en), .wr_index(s_wr_idx), .wr_data(s_wr_data),
    .issue_en(s_iss_en), .issue_index(s_iss_idx),
    .rd_en(s_rd_en[1:0]), .rd_index(a_rd_index),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_busy(a_rd_busy), .pend_any(a_pend_any)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .SYNC_READ(1), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .wr_en(s_wr_en), .wr_index(s_wr_idx[3:0]), .wr_data(b_wr_data),
    .issue_en(s_iss_en), .issue_index(s_iss_idx[3:0]),
    .rd_en(s_rd_en), .rd_index(b_rd_index),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_busy(b_rd_busy), .pend_any(b_pend_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   valid;
    logic [3:0]   busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [31:0] ma [32];
  logic        pa [32];
  logic [63:0] mb [16];
  logic        pb [16];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t exp_a();
    exp_t e;
    e.data  = '0;
    e.busy  = '0;
    e.valid = {2'b00, s_rd_en[1:0]};
    for (int p = 0; p < 2; p++) begin
      logic [4:0] idx;
      logic       fwd;
      idx = s_rd_idx[p];
      if (s_rd_en[p] && idx != 5'd0) begin
        fwd = s_wr_en && (s_wr_idx == idx);
        e.data[p*32 +: 32] = fwd ? s_wr_data : ma[idx];
        e.busy[p] = pa[idx] && !(fwd && !(s_iss_en && s_iss_idx == idx));
      end
    end
    return e;
  endfunction

  function automatic exp_t exp_b();
    exp_t e;
    e.data  = '0;
    e.busy  = '0;
    e.valid = s_rd_en;
    for (int p = 0; p < 4; p++) begin
      logic [3:0] idx;
      idx = s_rd_idx[p][3:0];
      if (s_rd_en[p]) begin
        e.data[p*64 +: 64] = mb[idx];
        e.busy[p] = pb[idx];
      end
    end
    return e;
  endfunction

  function automatic logic any_a();
    logic r = 1'b0;
    for (int i = 0; i < 32; i++) r |= pa[i];
    return r;
  endfunction

  function automatic logic any_b();
    logic r = 1'b0;
    for (int i = 0; i < 16; i++) r |= pb[i];
    return r;
  endfunction

  task automatic model_update();
    if (s_wr_en && s_wr_idx != 5'd0) ma[s_wr_idx] = s_wr_data;
    if (s_wr_en) pa[s_wr_idx] = 1'b0;
    if (s_iss_en) pa[s_iss_idx] = 1'b1;
    pa[0] = 1'b0;
    if (s_wr_en) begin
      mb[s_wr_idx[3:0]] = {s_wr_data ^ 32'h5A5A5A5A, s_wr_data};
      pb[s_wr_idx[3:0]] = 1'b0;
    end
    if (s_iss_en) pb[s_iss_idx[3:0]] = 1'b1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin ma[i] = '0; pa[i] = 1'b0; end
    for (int i = 0; i < 16; i++) begin mb[i] = '0; pb[i] = 1'b0; end
  endtask

  task automatic set_in(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ii, input logic [3:0] re,
                        input logic [4:0] i0, input logic [4:0] i1,
                        input logic [4:0] i2, input logic [4:0] i3);
    s_wr_en = we; s_wr_idx = wi; s_wr_data = wd;
    s_iss_en = ie; s_iss_idx = ii; s_rd_en = re;
    s_rd_idx[0] = i0; s_rd_idx[1] = i1; s_rd_idx[2] = i2; s_rd_idx[3] = i3;
  endtask

  task automatic idle_in();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // Called just after a rising edge with inputs set; ends just after the next one.
  task automatic step();
    exp_t e;
    @(negedge clk);
    q_a.push_back(exp_a());
    q_b.push_back(exp_b());
    e = q_a.pop_front();
    chk("a_data",  256'(a_rd_data),  e.data);
    chk("a_valid", 256'(a_rd_valid), 256'(e.valid));
    chk("a_busy",  256'(a_rd_busy),  256'(e.busy));
    if (q_b.size() >= 2) begin
      e = q_b.pop_front();
      chk("b_data",  b_rd_data,         e.data);
      chk("b_valid", 256'(b_rd_valid),  256'(e.valid));
      chk("b_busy",  256'(b_rd_busy),   256'(e.busy));
    end
    chk("a_pend", 256'(a_pend_any), 256'(any_a()));
    chk("b_pend", 256'(b_pend_any), 256'(any_b()));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    exp_t z;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_b_valid", 256'(b_rd_valid), 256'(0));
    chk("rst_b_data",  b_rd_data,        256'(0));
    chk("rst_a_pend",  256'(a_pend_any), 256'(0));
    model_clear();
    idle_in();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_b_valid", 256'(b_rd_valid), 256'(0));
    q_a.delete();
    q_b.delete();
    z.data = '0; z.valid = '0; z.busy = '0;
    q_b.push_back(z);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1;
    idle_in();
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Reset clears written data and discards an in-flight registered read
    set_in(1, 5'd5, 32'hDEADBEEF, 0, 0, 4'b0000, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 4'b1111, 5'd5, 5'd5, 5'd5, 5'd5); step();
    do_reset();
    set_in(0, 0, 0, 0, 0, 4'b1111, 5'd5, 5'd5, 5'd5, 5'd5); step();
    idle_in(); step();

    // Write then read port 1
    set_in(1, 5'd7, 32'h12345678, 0, 0, 4'b0000, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 4'b0010, 0, 5'd7, 0, 0); step();
    idle_in(); step();

    // Same-cycle write and read
    set_in(1, 5'd3, 32'h1, 0, 0, 4'b0000, 0, 0, 0, 0); step();
    set_in(1, 5'd3, 32'hA5A5A5A5, 0, 0, 4'b1111, 5'd3, 5'd3, 5'd3, 5'd3); step();
    set_in(0, 0, 0, 0, 0, 4'b1111, 5'd3, 5'd3, 5'd3, 5'd3); step();
    idle_in(); step();

    // Register 0 write and issue
    set_in(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 4'b0000, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 4'b1111, 0, 0, 0, 0); step();
    idle_in(); step();

    // Scoreboard: issue, writeback, simultaneous issue+write
    set_in(0, 0, 0, 1, 5'd9, 4'b0000, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 4'b0011, 5'd9, 5'd9, 0, 0); step();
    set_in(1, 5'd9, 32'h55, 0, 0, 4'b0011, 5'd9, 5'd9, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 4'b0011, 5'd9, 5'd9, 0, 0); step();
    set_in(1, 5'd9, 32'h55, 1, 5'd9, 4'b0001, 5'd9, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 4'b1111, 5'd9, 5'd9, 5'd9, 5'd9); step();
    idle_in(); step();

    // Multi-port: distinct, identical, port 2 disabled
    set_in(0, 0, 0, 0, 0, 4'b1111, 5'd3, 5'd5, 5'd7, 5'd9); step();
    set_in(0, 0, 0, 0, 0, 4'b1111, 5'd7, 5'd7, 5'd7, 5'd7); step();
    set_in(0, 0, 0, 0, 0, 4'b1011, 5'd3, 5'd5, 5'd7, 5'd9); step();
    idle_in(); step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
             1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
             4'($urandom_range(0, 15)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step();
    end
    idle_in(); step();
    idle_in(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
